// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ADD/SUB/MUL/DIV unit with start/done handshake.
// MUL is shift-add and DIV is restoring; both share one 2*WIDTH register.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   mul_s;
  logic [WIDTH:0]   div_t;
  logic [WIDTH:0]   div_s;
  logic [W2-1:0]    mul_p;
  logic [W2-1:0]    div_p;
  logic [W2-1:0]    step_p;
  logic             last;

  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s = {1'b0, a_q} - {1'b0, b_q};

  // MUL: p = {acc, multiplier}; add a when LSB set, then shift right
  assign mul_s = {1'b0, p_q[W2-1:WIDTH]}
               + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_p = {mul_s, p_q[WIDTH-1:1]};

  // DIV: p = {rem, quotient}; remainder < b so the restored value fits
  assign div_t = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
  assign div_s = div_t - {1'b0, b_q};
  assign div_p = div_s[WIDTH]
               ? {div_t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
               : {div_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign step_p = (op_q == OP_MUL) ? mul_p : div_p;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    res_d   = res_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          op_d    = opcode;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          p_d     = (opcode == OP_MUL)
                  ? {{WIDTH{1'b0}}, b}
                  : {{WIDTH{1'b0}}, a};
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            state_d = S_DONE;
            res_d   = add_s[WIDTH-1:0];
            hi_d    = '0;
            carry_d = add_s[WIDTH];
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                   && (add_s[WIDTH-1] != a_q[WIDTH-1]);
            zero_d  = (add_s[WIDTH-1:0] == '0);
            dbz_d   = 1'b0;
          end
          OP_SUB: begin
            state_d = S_DONE;
            res_d   = sub_s[WIDTH-1:0];
            hi_d    = '0;
            carry_d = sub_s[WIDTH];
            ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                   && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
            zero_d  = (sub_s[WIDTH-1:0] == '0);
            dbz_d   = 1'b0;
          end
          default: begin
            if (op_q == OP_DIV && b_q == '0) begin
              state_d = S_DONE;
              res_d   = '1;
              hi_d    = a_q;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              zero_d  = 1'b0;
              dbz_d   = 1'b1;
            end else begin
              p_d   = step_p;
              cnt_d = cnt_q + CW'(1);
              if (last) begin
                state_d = S_DONE;
                res_d   = step_p[WIDTH-1:0];
                hi_d    = step_p[W2-1:WIDTH];
                carry_d = (op_q == OP_MUL)
                       && (step_p[W2-1:WIDTH] != '0);
                ovf_d   = 1'b0;
                zero_d  = (step_p == '0);
                dbz_d   = 1'b0;
              end
            end
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign dbz       = dbz_q;

endmodule
